imem_loader: RTL and testbench

//  Boot-time writer for the instruction memory: the write side of the port the
//  CPU only reads. Accepts a byte stream (valid/ready), assembles little-endian
//  32-bit words, writes them to sequential word addresses from 0, and holds the

---
 rtl/imem_loader_if.sv | 10 +
 rtl/imem_loader.sv | 125 ++++++++++++
 tb/tb_imem_loader.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream handshake bus feeding the instruction-memory loader.
// The byte source uses the master modport; the loader uses the slave modport.
interface imem_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: takes a length-prefixed byte stream, writes little-endian
// words to instruction memory from address 0, and holds the CPU in reset until done.
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    imem_loader_if.slave      stream,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wd,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, DONE, ERROR} state_t;

    state_t            state;
    state_t            state_next;
    logic              ready;
    logic              accept;
    logic [7:0]        len_lo;
    logic [15:0]       word_count;
    logic [15:0]       len_value;
    logic              len_bad;
    logic [1:0]        byte_cnt;
    logic [23:0]       partial;
    logic [ADDR_W:0]   word_idx;
    logic              last_word;
    logic              restart;

    assign stream.in_ready = ready;
    assign accept    = stream.in_valid & ready;
    assign len_value = {stream.in_data, len_lo};
    assign len_bad   = (len_value == 16'd0) || (32'(len_value) > 32'(DEPTH));
    assign last_word = ((32'(word_idx) + 32'd1) == 32'(word_count));
    assign restart   = start && (state == IDLE || state == DONE || state == ERROR);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            IDLE: if (start) state_next = LEN0;
            LEN0: begin
                ready = 1'b1;
                busy  = 1'b1;
                if (accept) state_next = LEN1;
            end
            LEN1: begin
                ready = 1'b1;
                busy  = 1'b1;
                if (accept) state_next = len_bad ? ERROR : DATA;
            end
            DATA: begin
                ready = 1'b1;
                busy  = 1'b1;
                if (accept && byte_cnt == 2'd3 && last_word) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_next = LEN0;
            end
            ERROR: begin
                error = 1'b1;
                if (start) state_next = LEN0;
            end
            default: state_next = IDLE;
        endcase
    end

    // cpu_reset drops only once DONE has lasted a full cycle, i.e. after the final write pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wd     <= '0;
            cpu_reset  <= 1'b1;
            len_lo     <= '0;
            word_count <= '0;
            byte_cnt   <= '0;
            partial    <= '0;
            word_idx   <= '0;
        end else begin
            mem_we    <= 1'b0;
            cpu_reset <= !(state == DONE && state_next == DONE);
            if (restart) begin
                byte_cnt <= '0;
                partial  <= '0;
                word_idx <= '0;
            end
            if (accept) begin
                case (state)
                    LEN0: len_lo <= stream.in_data;
                    LEN1: word_count <= len_value;
                    DATA: begin
                        if (byte_cnt == 2'd3) begin
                            mem_we   <= 1'b1;
                            mem_addr <= word_idx[ADDR_W-1:0];
                            mem_wd   <= {stream.in_data, partial};
                            word_idx <= word_idx + 1'b1;
                            byte_cnt <= '0;
                        end else begin
                            partial  <= {stream.in_data, partial[23:8]};
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader; expected writes come from
// decoding the byte stream directly (length prefix, then little-endian words).
module tb_imem_loader;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wd;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              error;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0]        bytes_q[$];
    logic [ADDR_W-1:0] cap_addr[$];
    logic [31:0]       cap_wd[$];
    logic [ADDR_W-1:0] exp_addr[$];
    logic [31:0]       exp_wd[$];
    logic              exp_err;

    imem_loader_if bus ();

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .stream(bus),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            cap_addr.push_back(mem_addr);
            cap_wd.push_back(mem_wd);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Decode the stream as a whole: word count, then each word assembled LSB first.
    task automatic build_model();
        int n;
        exp_addr.delete();
        exp_wd.delete();
        n = int'(bytes_q[0]) + 256 * int'(bytes_q[1]);
        exp_err = (n == 0) || (n > DEPTH);
        if (!exp_err && bytes_q.size() >= 2 + 4 * n) begin
            for (int i = 0; i < n; i++) begin
                exp_addr.push_back(ADDR_W'(i));
                exp_wd.push_back(int'(bytes_q[2+4*i]) + (int'(bytes_q[3+4*i]) << 8) +
                                 (int'(bytes_q[4+4*i]) << 16) + (int'(bytes_q[5+4*i]) << 24));
            end
        end
    endtask

    task automatic clear_capture();
        cap_addr.delete();
        cap_wd.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents bytes_q; every cycle checks that a write strobe appears exactly one cycle after a word's 4th byte.
    task automatic send_stream(input bit rand_gaps, input bit expect_writes);
        bit pend;
        bit accepted;
        int waited;
        pend = 1'b0;
        for (int idx = 0; idx < bytes_q.size(); idx++) begin
            accepted = 1'b0;
            waited = 0;
            while (!accepted) begin
                @(negedge clk);
                tests_run++;
                if (mem_we !== pend) begin
                    tests_failed++;
                    $display("[TB] FAIL write_strobe before byte %0d: mem_we=%b expected %b", idx, mem_we, pend);
                end
                pend = 1'b0;
                if (rand_gaps && $urandom_range(0, 1) == 1) begin
                    bus.in_valid = 1'b0;
                    bus.in_data  = 8'($urandom);
                end else begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = bytes_q[idx];
                    if (bus.in_ready === 1'b1) begin
                        accepted = 1'b1;
                        pend = expect_writes && idx >= 2 && ((idx - 2) % 4 == 3);
                    end
                end
                waited++;
                if (!accepted && waited > 100) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL handshake_timeout byte %0d: in_ready=%b expected 1", idx, bus.in_ready);
                    bus.in_valid = 1'b0;
                    return;
                end
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        tests_run++;
        if (mem_we !== pend) begin
            tests_failed++;
            $display("[TB] FAIL final_strobe: mem_we=%b expected %b", mem_we, pend);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run += 8;
        if (bus.in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        if (mem_we !== 1'b0)       begin tests_failed++; $display("[TB] FAIL reset_mem_we: got %b want 0", mem_we); end
        if (mem_addr !== '0)       begin tests_failed++; $display("[TB] FAIL reset_mem_addr: got %h want 0", mem_addr); end
        if (mem_wd !== 32'h0)      begin tests_failed++; $display("[TB] FAIL reset_mem_wd: got %h want 0", mem_wd); end
        if (busy !== 1'b0)         begin tests_failed++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0)         begin tests_failed++; $display("[TB] FAIL reset_done: got %b want 0", done); end
        if (error !== 1'b0)        begin tests_failed++; $display("[TB] FAIL reset_error: got %b want 0", error); end
        if (cpu_reset !== 1'b1)    begin tests_failed++; $display("[TB] FAIL reset_cpu_reset: got %b want 1", cpu_reset); end
    endtask

    task automatic test_single_word();
        clear_capture();
        do_start();
        bytes_q = {8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        build_model();
        send_stream(1'b0, 1'b1);
        tests_run += 6;
        if (mem_we !== 1'b1)       begin tests_failed++; $display("[TB] FAIL single_we: got %b want 1", mem_we); end
        if (mem_addr !== exp_addr[0]) begin tests_failed++; $display("[TB] FAIL single_addr: got %h want %h", mem_addr, exp_addr[0]); end
        if (mem_wd !== exp_wd[0])  begin tests_failed++; $display("[TB] FAIL single_wd: got %h want %h", mem_wd, exp_wd[0]); end
        if (done !== 1'b1)         begin tests_failed++; $display("[TB] FAIL single_done: got %b want 1", done); end
        if (bus.in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_in_ready: got %b want 0", bus.in_ready); end
        if (cpu_reset !== 1'b1)    begin tests_failed++; $display("[TB] FAIL single_cpu_reset_early: got %b want 1", cpu_reset); end
        @(negedge clk);
        tests_run += 3;
        if (cpu_reset !== 1'b0)    begin tests_failed++; $display("[TB] FAIL single_cpu_reset_release: got %b want 0", cpu_reset); end
        if (mem_we !== 1'b0)       begin tests_failed++; $display("[TB] FAIL single_we_pulse: got %b want 0", mem_we); end
        if (mem_wd !== exp_wd[0])  begin tests_failed++; $display("[TB] FAIL single_wd_hold: got %h want %h", mem_wd, exp_wd[0]); end
    endtask

    task automatic test_random_gaps();
        clear_capture();
        do_start();
        tests_run += 2;
        if (cpu_reset !== 1'b1) begin tests_failed++; $display("[TB] FAIL restart_cpu_reset: got %b want 1", cpu_reset); end
        if (busy !== 1'b1)      begin tests_failed++; $display("[TB] FAIL restart_busy: got %b want 1", busy); end
        bytes_q = {8'h03, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                   8'hFF, 8'hFF, 8'hFF, 8'hFF};
        build_model();
        send_stream(1'b1, 1'b1);
        repeat (3) @(negedge clk);
        tests_run += 2;
        if (done !== 1'b1) begin tests_failed++; $display("[TB] FAIL gaps_done: got %b want 1", done); end
        if (cap_addr.size() != exp_addr.size()) begin tests_failed++; $display("[TB] FAIL gaps_count: got %0d writes want %0d", cap_addr.size(), exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < cap_addr.size(); i++) begin
            tests_run++;
            if (cap_addr[i] !== exp_addr[i] || cap_wd[i] !== exp_wd[i]) begin
                tests_failed++;
                $display("[TB] FAIL gaps_word %0d: got %h@%h want %h@%h", i, cap_wd[i], cap_addr[i], exp_wd[i], exp_addr[i]);
            end
        end
    endtask

    task automatic test_zero_len();
        clear_capture();
        do_start();
        bytes_q = {8'h00, 8'h00};
        build_model();
        send_stream(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        tests_run += 5;
        if (error !== exp_err)     begin tests_failed++; $display("[TB] FAIL zero_error: got %b want %b", error, exp_err); end
        if (bus.in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_in_ready: got %b want 0", bus.in_ready); end
        if (cpu_reset !== 1'b1)    begin tests_failed++; $display("[TB] FAIL zero_cpu_reset: got %b want 1", cpu_reset); end
        if (done !== 1'b0)         begin tests_failed++; $display("[TB] FAIL zero_done: got %b want 0", done); end
        if (cap_addr.size() != 0)  begin tests_failed++; $display("[TB] FAIL zero_writes: got %0d writes want 0", cap_addr.size()); end
    endtask

    task automatic test_len_bounds();
        clear_capture();
        do_start();
        bytes_q = {8'h01, 8'h01};
        build_model();
        send_stream(1'b0, 1'b0);
        repeat (2) @(negedge clk);
        tests_run += 2;
        if (error !== exp_err)    begin tests_failed++; $display("[TB] FAIL over_error: got %b want %b", error, exp_err); end
        if (cap_addr.size() != 0) begin tests_failed++; $display("[TB] FAIL over_writes: got %0d writes want 0", cap_addr.size()); end

        clear_capture();
        do_start();
        tests_run++;
        if (error !== 1'b0) begin tests_failed++; $display("[TB] FAIL error_clear: got %b want 0", error); end
        bytes_q = {8'(DEPTH), 8'(DEPTH >> 8)};
        for (int i = 0; i < 4 * DEPTH; i++) bytes_q.push_back(8'($urandom));
        build_model();
        send_stream(1'b0, 1'b1);
        repeat (2) @(negedge clk);
        tests_run += 3;
        if (done !== 1'b1) begin tests_failed++; $display("[TB] FAIL full_done: got %b want 1", done); end
        if (cap_addr.size() != DEPTH) begin tests_failed++; $display("[TB] FAIL full_count: got %0d writes want %0d", cap_addr.size(), DEPTH); end
        if (mem_addr !== ADDR_W'(DEPTH - 1)) begin tests_failed++; $display("[TB] FAIL full_last_addr: got %h want %h", mem_addr, ADDR_W'(DEPTH - 1)); end
        for (int i = 0; i < exp_addr.size() && i < cap_addr.size(); i++) begin
            tests_run++;
            if (cap_addr[i] !== exp_addr[i] || cap_wd[i] !== exp_wd[i]) begin
                tests_failed++;
                $display("[TB] FAIL full_word %0d: got %h@%h want %h@%h", i, cap_wd[i], cap_addr[i], exp_wd[i], exp_addr[i]);
            end
        end
    endtask

    task automatic test_reset_midload();
        clear_capture();
        do_start();
        bytes_q = {8'h01, 8'h00, 8'hAA, 8'hBB};
        send_stream(1'b0, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        tests_run += 5;
        if (mem_we !== 1'b0)       begin tests_failed++; $display("[TB] FAIL midreset_we: got %b want 0", mem_we); end
        if (busy !== 1'b0)         begin tests_failed++; $display("[TB] FAIL midreset_busy: got %b want 0", busy); end
        if (bus.in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_in_ready: got %b want 0", bus.in_ready); end
        if (cpu_reset !== 1'b1)    begin tests_failed++; $display("[TB] FAIL midreset_cpu_reset: got %b want 1", cpu_reset); end
        if (cap_addr.size() != 0)  begin tests_failed++; $display("[TB] FAIL midreset_writes: got %0d writes want 0", cap_addr.size()); end
        reset = 1'b0;

        clear_capture();
        do_start();
        bytes_q = {8'h01, 8'h00};
        for (int i = 0; i < 4; i++) bytes_q.push_back(8'($urandom));
        build_model();
        send_stream(1'b0, 1'b1);
        repeat (2) @(negedge clk);
        tests_run++;
        if (cap_addr.size() != 1) begin tests_failed++; $display("[TB] FAIL reload_count: got %0d writes want 1", cap_addr.size()); end
        if (cap_addr.size() >= 1) begin
            tests_run++;
            if (cap_addr[0] !== exp_addr[0] || cap_wd[0] !== exp_wd[0]) begin
                tests_failed++;
                $display("[TB] FAIL reload_word: got %h@%h want %h@%h", cap_wd[0], cap_addr[0], exp_wd[0], exp_addr[0]);
            end
        end
    endtask

    task automatic test_restart_from_done();
        for (int iter = 0; iter < 4; iter++) begin
            tests_run++;
            if (cpu_reset !== 1'b0) begin tests_failed++; $display("[TB] FAIL done_cpu_reset iter %0d: got %b want 0", iter, cpu_reset); end
            clear_capture();
            do_start();
            tests_run++;
            if (cpu_reset !== 1'b1) begin tests_failed++; $display("[TB] FAIL restart_reassert iter %0d: got %b want 1", iter, cpu_reset); end
            bytes_q = {8'($urandom_range(1, 6)), 8'h00};
            for (int i = 0; i < 4 * int'(bytes_q[0]); i++) bytes_q.push_back(8'($urandom));
            build_model();
            send_stream(1'b1, 1'b1);
            tests_run++;
            if (cpu_reset !== 1'b1) begin tests_failed++; $display("[TB] FAIL restart_hold iter %0d: got %b want 1", iter, cpu_reset); end
            @(negedge clk);
            tests_run++;
            if (cap_addr.size() != exp_addr.size()) begin tests_failed++; $display("[TB] FAIL restart_count iter %0d: got %0d want %0d", iter, cap_addr.size(), exp_addr.size()); end
            for (int i = 0; i < exp_addr.size() && i < cap_addr.size(); i++) begin
                tests_run++;
                if (cap_addr[i] !== exp_addr[i] || cap_wd[i] !== exp_wd[i]) begin
                    tests_failed++;
                    $display("[TB] FAIL restart_word %0d/%0d: got %h@%h want %h@%h", iter, i, cap_wd[i], cap_addr[i], exp_wd[i], exp_addr[i]);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        test_reset();
        test_single_word();
        test_random_gaps();
        test_zero_len();
        test_len_bounds();
        test_reset_midload();
        test_restart_from_done();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
